rocc_accum_responder: RTL and testbench
=======================================

ROCC_ACCUM_RESPONDER -- requirements
Module: rocc_accum_responder

Interface
REQ-001 Parameter XLEN, default 64, data width of operands, accumulators and response data.
REQ-002 Parameter NumAcc, default 4, accumulator count, power of two, 2..4.
REQ-003 clk_i  input  1  single clock, all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 rocc_cmd_valid_i  input  1  core presents a command.
REQ-006 rocc_cmd_ready_o  output  1  responder accepts the command this cycle.
REQ-007 rocc_cmd_funct_i  input  7  [2:0] opcode, [6:5] accumulator index, [4:3] ignored.
REQ-008 rocc_cmd_rs1_i  input  XLEN  operand 1.
REQ-009 rocc_cmd_rs2_i  input  XLEN  operand 2.
REQ-010 rocc_cmd_rd_i  input  5  destination register tag.
REQ-011 rocc_cmd_xd_i  input  1  core expects a response.
REQ-012 rocc_resp_valid_o  output  1  response available.
REQ-013 rocc_resp_ready_i  input  1  core accepts the response.
REQ-014 rocc_resp_rd_o  output  5  echo of the accepted rd.
REQ-015 rocc_resp_data_o  output  XLEN  response payload.
REQ-016 busy_o  output  1  high whenever state is not IDLE.
REQ-017 illegal_o  output  1  one-cycle pulse on acceptance of an unsupported opcode.

Function
REQ-018 FSM states: IDLE, EXEC, RESP; rocc_cmd_ready_o = 1 only in IDLE; command accepted when valid and ready are both high.
REQ-019 Accept rd, xd, opcode and index into internal registers; inputs are don't-care after acceptance.
REQ-020 Index = funct[6:5] truncated to log2(NumAcc) bits; with NumAcc < 4 the upper index bits are ignored.
REQ-021 Op 0 WRITE: acc[idx] <= rs1; response data = previous acc[idx].
REQ-022 Op 1 READ: no state change; response data = acc[idx].
REQ-023 Op 2 ADD: acc[idx] <= acc[idx] + rs1, modulo 2^XLEN; response data = new value.
REQ-024 Op 3 MAC: acc[idx] <= acc[idx] + low XLEN bits of rs1*rs2 (unsigned); response data = new value.
REQ-025 Op 4 CLEAR: all accumulators <= 0; response data = 0.
REQ-026 Ops 5..7: no accumulator change; illegal_o high in the acceptance cycle +1; response data = 0.
REQ-027 Single-cycle ops (0,1,2,4,illegal): accepted at edge T, accumulator updated at T+1, rocc_resp_valid_o high from T+1 when xd = 1.
REQ-028 MAC: IDLE -> EXEC; shift-add multiplier consuming 1 multiplier bit per cycle; exactly XLEN cycles in EXEC; accumulator updated and rocc_resp_valid_o high at T+XLEN+1 when xd = 1.
REQ-029 xd = 0: operation still executes; no response; return to IDLE after update (T+1, or T+XLEN+1 for MAC).
REQ-030 RESP: rocc_resp_valid_o, rocc_resp_rd_o and rocc_resp_data_o held stable until rocc_resp_ready_i; on handshake -> IDLE next cycle.
REQ-031 No command accepted in the response-handshake cycle; minimum one-cycle bubble between response and next acceptance.
REQ-032 rocc_resp_valid_o = 0 in IDLE and EXEC; rocc_resp_data_o = 0 and rocc_resp_rd_o = 0 whenever rocc_resp_valid_o = 0.
REQ-033 MAC multiplier with rs2 = 0 or rs1 = 0 still takes XLEN cycles (fixed latency).
REQ-034 rocc_resp_ready_i high while rocc_resp_valid_o low has no effect.

Reset
REQ-035 rst_i high at an edge: state IDLE, all accumulators 0, multiplier registers 0, rocc_resp_valid_o 0, rocc_resp_data_o 0, rocc_resp_rd_o 0, busy_o 0, illegal_o 0, rocc_cmd_ready_o 1 from the first cycle after rst_i falls.
REQ-036 rst_i mid-EXEC or mid-RESP aborts the operation; no response is produced; the accumulator is not updated.
REQ-037 rst_i has priority over any simultaneous command or response handshake.

Verification
REQ-038 WRITE idx2 rs1=0x1234, xd=1 -> resp at T+1, data 0, rd echoed; then READ idx2 -> data 0x1234.
REQ-039 ADD idx0 rs1=0xFFFF_FFFF_FFFF_FFFF twice after WRITE idx0=1 -> data 0, then 0xFFFF_FFFF_FFFF_FFFF (wrap-around).
REQ-040 MAC idx1 rs1=3 rs2=5 from acc=10, xd=1 -> busy_o high 65 cycles, resp at T+65 data 25; cmd_ready_o low throughout.
REQ-041 Hold rocc_resp_ready_i low 10 cycles with a pending response while driving a new cmd_valid -> response stable, new command not accepted until cycle after handshake.
REQ-042 Opcode 6 with xd=1 -> illegal_o single pulse, resp data 0, all accumulators unchanged; opcode 4 -> all READs return 0.
REQ-043 Assert rst_i at EXEC cycle 20 of a MAC -> no response ever, READ of target returns 0, cmd_ready_o 1 after reset.

Source files
------------

// File: rtl/rocc_accum_responder_if.sv
// RoCC command/response channel between the core (master) and the accumulator
// responder (slave).
interface rocc_accum_responder_if #(
    parameter int XLEN = 64
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [6:0]      cmd_funct;
    logic [XLEN-1:0] cmd_rs1;
    logic [XLEN-1:0] cmd_rs2;
    logic [4:0]      cmd_rd;
    logic            cmd_xd;
    logic            resp_valid;
    logic            resp_ready;
    logic [4:0]      resp_rd;
    logic [XLEN-1:0] resp_data;

    modport master (
        output cmd_valid, cmd_funct, cmd_rs1, cmd_rs2, cmd_rd, cmd_xd, resp_ready,
        input  cmd_ready, resp_valid, resp_rd, resp_data
    );

    modport slave (
        input  cmd_valid, cmd_funct, cmd_rs1, cmd_rs2, cmd_rd, cmd_xd, resp_ready,
        output cmd_ready, resp_valid, resp_rd, resp_data
    );
endinterface

// File: rtl/rocc_accum_responder.sv
// RoCC accelerator holding NumAcc accumulators; supports write/read/add/clear in
// one cycle and a fixed-latency shift-add multiply-accumulate.
module rocc_accum_responder #(
    parameter int XLEN   = 64,
    parameter int NumAcc = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    rocc_accum_responder_if.slave  rocc,
    output logic                   busy_o,
    output logic                   illegal_o
);
    localparam int IdxW = $clog2(NumAcc);
    localparam int CntW = $clog2(XLEN + 1);

    localparam logic [2:0] OpWrite = 3'd0;
    localparam logic [2:0] OpRead  = 3'd1;
    localparam logic [2:0] OpAdd   = 3'd2;
    localparam logic [2:0] OpMac   = 3'd3;
    localparam logic [2:0] OpClear = 3'd4;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    logic [XLEN-1:0] acc [NumAcc];
    logic [2:0]      op_q;
    logic [IdxW-1:0] idx_q;
    logic [4:0]      rd_q;
    logic            xd_q;
    logic [XLEN-1:0] mcand_q;   // rs1 for every op; shifted multiplicand for MAC
    logic [XLEN-1:0] mplier_q;
    logic [XLEN-1:0] product_q;
    logic [CntW-1:0] cnt_q;

    logic [XLEN-1:0] cur_val;
    logic [XLEN-1:0] new_val;
    logic [XLEN-1:0] result;
    logic            acc_we;
    logic            clear_all;
    logic            mac_stepping;

    assign rocc.cmd_ready = (state == IDLE);
    assign busy_o         = (state != IDLE);
    assign cur_val        = acc[idx_q];
    assign mac_stepping   = (op_q == OpMac) && (cnt_q != CntW'(XLEN));

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        new_val   = '0;
        result    = '0;
        acc_we    = 1'b0;
        clear_all = 1'b0;
        case (op_q)
            OpWrite: begin
                new_val = mcand_q;
                acc_we  = 1'b1;
                result  = cur_val;
            end
            OpRead: result = cur_val;
            OpAdd: begin
                new_val = cur_val + mcand_q;
                acc_we  = 1'b1;
                result  = new_val;
            end
            OpMac: begin
                new_val = cur_val + product_q;
                acc_we  = 1'b1;
                result  = new_val;
            end
            OpClear: clear_all = 1'b1;
            default: result = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            op_q            <= '0;
            idx_q           <= '0;
            rd_q            <= '0;
            xd_q            <= 1'b0;
            mcand_q         <= '0;
            mplier_q        <= '0;
            product_q       <= '0;
            cnt_q           <= '0;
            illegal_o       <= 1'b0;
            rocc.resp_valid <= 1'b0;
            rocc.resp_data  <= '0;
            rocc.resp_rd    <= '0;
            // NOTE: the accumulators are architecturally visible, so unlike a plain
            // storage array they must be cleared by reset.
            for (int i = 0; i < NumAcc; i++) acc[i] <= '0;
        end else begin
            illegal_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (rocc.cmd_valid) begin
                        op_q      <= rocc.cmd_funct[2:0];
                        idx_q     <= rocc.cmd_funct[5 +: IdxW];
                        rd_q      <= rocc.cmd_rd;
                        xd_q      <= rocc.cmd_xd;
                        mcand_q   <= rocc.cmd_rs1;
                        mplier_q  <= rocc.cmd_rs2;
                        product_q <= '0;
                        cnt_q     <= '0;
                        illegal_o <= (rocc.cmd_funct[2:0] > OpClear);
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (mac_stepping) begin
                        // One multiplier bit per cycle; latency is fixed at XLEN steps.
                        if (mplier_q[0]) product_q <= product_q + mcand_q;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CntW'(1);
                    end else begin
                        if (clear_all) begin
                            for (int i = 0; i < NumAcc; i++) acc[i] <= '0;
                        end else if (acc_we) begin
                            acc[idx_q] <= new_val;
                        end
                        if (xd_q) begin
                            rocc.resp_valid <= 1'b1;
                            rocc.resp_data  <= result;
                            rocc.resp_rd    <= rd_q;
                            state           <= RESP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                RESP: begin
                    if (rocc.resp_ready) begin
                        rocc.resp_valid <= 1'b0;
                        rocc.resp_data  <= '0;
                        rocc.resp_rd    <= '0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rocc_accum_responder.sv
// Directed self-checking bench for rocc_accum_responder (XLEN=64, NumAcc=4).
module tb_rocc_accum_responder;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk;
    logic rst;
    logic busy;
    logic illegal;
    int   total;
    int   bad;

    rocc_accum_responder_if #(.XLEN(64)) rocc ();

    rocc_accum_responder #(.XLEN(64), .NumAcc(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .rocc      (rocc),
        .busy_o    (busy),
        .illegal_o (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and hold it until accepted; returns just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [1:0] idx, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd, input logic xd);
        rocc.cmd_valid = 1'b1;
        rocc.cmd_funct = {idx, 2'b11, op};
        rocc.cmd_rs1   = a;
        rocc.cmd_rs2   = b;
        rocc.cmd_rd    = rd;
        rocc.cmd_xd    = xd;
        for (int i = 0; i < 200; i++) begin
            if (rocc.cmd_ready) break;
            tick();
        end
        check("cmd_ready_before_accept", {63'd0, rocc.cmd_ready}, 64'd1);
        tick();
        rocc.cmd_valid = 1'b0;
        rocc.cmd_funct = 7'($urandom);
        rocc.cmd_rs1   = {$urandom, $urandom};
        rocc.cmd_rs2   = {$urandom, $urandom};
        rocc.cmd_rd    = 5'($urandom);
        rocc.cmd_xd    = 1'($urandom);
    endtask

    task automatic wait_resp(output int lat);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (rocc.resp_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic take_resp();
        rocc.resp_ready = 1'b1;
        tick();
        rocc.resp_ready = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [1:0] idx,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                         input logic [63:0] exp_data, input int exp_lat);
        int lat;
        issue(op, idx, a, b, rd, 1'b1);
        wait_resp(lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_data"}, rocc.resp_data, exp_data);
        check({tag, "_rd"}, {59'd0, rocc.resp_rd}, {59'd0, rd});
        take_resp();
    endtask

    initial begin
        int errs;
        int lat;
        logic [63:0] exp_acc [4];
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        rocc.cmd_valid  = 1'b0;
        rocc.cmd_funct  = '0;
        rocc.cmd_rs1    = '0;
        rocc.cmd_rs2    = '0;
        rocc.cmd_rd     = '0;
        rocc.cmd_xd     = 1'b0;
        rocc.resp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("rst_cmd_ready",  {63'd0, rocc.cmd_ready},  64'd1);
        check("rst_resp_valid", {63'd0, rocc.resp_valid}, 64'd0);
        check("rst_resp_data",  rocc.resp_data,           64'd0);
        check("rst_resp_rd",    {59'd0, rocc.resp_rd},    64'd0);
        check("rst_busy",       {63'd0, busy},            64'd0);
        check("rst_illegal",    {63'd0, illegal},         64'd0);

        // resp_ready while idle is ignored
        rocc.resp_ready = 1'b1;
        tick();
        tick();
        check("idle_ready_valid", {63'd0, rocc.resp_valid}, 64'd0);
        check("idle_ready_cmdrdy", {63'd0, rocc.cmd_ready}, 64'd1);
        rocc.resp_ready = 1'b0;

        do_op("write2", 3'd0, 2'd2, 64'h1234, 64'd0, 5'd7, 64'd0, 1);
        do_op("read2",  3'd1, 2'd2, 64'd0,    64'd0, 5'd8, 64'h1234, 1);

        do_op("write0", 3'd0, 2'd0, 64'd1, 64'd0, 5'd1, 64'd0, 1);
        do_op("add0a",  3'd2, 2'd0, ONES,  64'd0, 5'd2, 64'd0, 1);
        do_op("add0b",  3'd2, 2'd0, ONES,  64'd0, 5'd3, ONES, 1);

        // MAC timing: busy and no ready for the whole multiply, response at T+65
        do_op("write1", 3'd0, 2'd1, 64'd10, 64'd0, 5'd4, 64'd0, 1);
        issue(3'd3, 2'd1, 64'd3, 64'd5, 5'd11, 1'b1);
        errs = 0;
        if (!busy || rocc.cmd_ready || rocc.resp_valid) errs++;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (!busy || rocc.cmd_ready || rocc.resp_valid) errs++;
        end
        check("mac_exec_window_errs", 64'(errs), 64'd0);
        tick();
        check("mac_valid_t65", {63'd0, rocc.resp_valid}, 64'd1);
        check("mac_data",      rocc.resp_data,           64'd25);
        check("mac_rd",        {59'd0, rocc.resp_rd},    64'd11);
        check("mac_busy_resp", {63'd0, busy},            64'd1);
        take_resp();
        check("mac_busy_after", {63'd0, busy}, 64'd0);

        // Backpressure: response held 10 cycles while a new command waits
        do_op("write3", 3'd0, 2'd3, 64'h55, 64'd0, 5'd9, 64'd0, 1);
        issue(3'd0, 2'd3, 64'h77, 64'd0, 5'd9, 1'b1);
        wait_resp(lat);
        check("bp_lat", 64'(lat), 64'd1);
        rocc.cmd_valid = 1'b1;
        rocc.cmd_funct = 7'b11_00_001;
        rocc.cmd_rd    = 5'd4;
        rocc.cmd_xd    = 1'b1;
        errs = 0;
        for (int k = 0; k < 10; k++) begin
            if (!rocc.resp_valid || rocc.resp_data !== 64'h55 || rocc.resp_rd !== 5'd9
                || rocc.cmd_ready) errs++;
            tick();
        end
        check("bp_hold_errs", 64'(errs), 64'd0);
        take_resp();
        check("bp_not_accepted_at_hs", {63'd0, rocc.cmd_ready},  64'd1);
        check("bp_valid_dropped",      {63'd0, rocc.resp_valid}, 64'd0);
        tick();
        rocc.cmd_valid = 1'b0;
        check("bp_accepted_next", {63'd0, busy}, 64'd1);
        wait_resp(lat);
        check("bp_read_lat",  64'(lat),              64'd1);
        check("bp_read_data", rocc.resp_data,        64'h77);
        check("bp_read_rd",   {59'd0, rocc.resp_rd}, 64'd4);
        take_resp();

        // Illegal opcode: one-cycle pulse, zero data, no state change
        issue(3'd6, 2'd1, 64'h9999, 64'h3, 5'd13, 1'b1);
        check("ill_pulse", {63'd0, illegal}, 64'd1);
        wait_resp(lat);
        check("ill_pulse_end", {63'd0, illegal}, 64'd0);
        check("ill_lat",  64'(lat),              64'd1);
        check("ill_data", rocc.resp_data,        64'd0);
        check("ill_rd",   {59'd0, rocc.resp_rd}, 64'd13);
        take_resp();
        exp_acc[0] = ONES;
        exp_acc[1] = 64'd25;
        exp_acc[2] = 64'h1234;
        exp_acc[3] = 64'h77;
        for (int i = 0; i < 4; i++)
            do_op($sformatf("ill_keep%0d", i), 3'd1, 2'(i), 64'd0, 64'd0, 5'(i + 16), exp_acc[i], 1);

        do_op("clear", 3'd4, 2'd2, 64'd5, 64'd0, 5'd20, 64'd0, 1);
        for (int i = 0; i < 4; i++)
            do_op($sformatf("clr_read%0d", i), 3'd1, 2'(i), 64'd0, 64'd0, 5'(i), 64'd0, 1);

        // xd=0: executes silently
        issue(3'd0, 2'd0, 64'hABC, 64'd0, 5'd5, 1'b0);
        errs = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (rocc.resp_valid) errs++;
        end
        check("nox_no_resp", 64'(errs), 64'd0);
        do_op("nox_read", 3'd1, 2'd0, 64'd0, 64'd0, 5'd6, 64'hABC, 1);

        // Wide MAC and zero-multiplier MAC keep fixed latency
        do_op("mac_wide", 3'd3, 2'd2, 64'h1_0000_0001, 64'hFFFF_FFFF, 5'd21, ONES, 65);
        do_op("mac_zero", 3'd3, 2'd2, 64'd5, 64'd0, 5'd22, ONES, 65);

        // Reset mid-MAC aborts: no response, accumulators cleared
        issue(3'd3, 2'd1, 64'd7, 64'd9, 5'd23, 1'b1);
        for (int k = 0; k < 20; k++) tick();
        rst = 1'b1;
        rocc.resp_ready = 1'b1;
        tick();
        rst = 1'b0;
        rocc.resp_ready = 1'b0;
        check("abort_cmd_ready", {63'd0, rocc.cmd_ready}, 64'd1);
        errs = 0;
        for (int k = 0; k < 70; k++) begin
            tick();
            if (rocc.resp_valid || busy) errs++;
        end
        check("abort_no_resp", 64'(errs), 64'd0);
        do_op("abort_read1", 3'd1, 2'd1, 64'd0, 64'd0, 5'd24, 64'd0, 1);
        do_op("abort_read0", 3'd1, 2'd0, 64'd0, 64'd0, 5'd25, 64'd0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
